// File: rtl/std_cache_bypass_arbiter.sv
// rtl/std_cache_bypass_arbiter.sv - round-robin arbiter for uncached/bypass requests onto one AXI adapter
//
// Purpose:
//   Collects bypass requests from NumPorts cache-controller ports and forwards
//   one at a time to the bypass AXI adapter. The adapter's grant and response
//   are returned only to the port that owns the transaction in flight.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   req_ports_i  per-port bypass requests
//   rsp_ports_o  per-port bypass responses (only the owner ever sees gnt/valid)
//   req_o        request to the AXI adapter
//   rsp_i        response from the AXI adapter
//   busy_o       high while a transaction is in flight

package std_cache_bypass_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [7:0]  be;
    logic [3:0]  id;
    logic [63:0] addr;
    logic [63:0] wdata;
  } bypass_req_t;

  typedef struct packed {
    logic        gnt;
    logic        valid;
    logic [63:0] rdata;
  } bypass_rsp_t;

endpackage

module std_cache_bypass_arbiter
  import std_cache_bypass_pkg::*;
#(
  parameter int unsigned NumPorts = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  bypass_req_t [NumPorts-1:0] req_ports_i,
  output bypass_rsp_t [NumPorts-1:0] rsp_ports_o,
  output bypass_req_t                req_o,
  input  bypass_rsp_t                rsp_i,
  output logic                       busy_o
);

  localparam int unsigned PtrW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] rr_q;
  logic [PtrW-1:0] owner_q;
  bypass_req_t     payload_q;

  logic [PtrW-1:0] winner;
  logic            any_req;
  logic            complete;
  logic [PtrW-1:0] rr_next;
  int unsigned     scan_idx;

  // Round-robin search: first requester at or after rr_q, wrapping.
  always_comb begin
    any_req  = 1'b0;
    winner   = '0;
    scan_idx = 0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      scan_idx = 32'(rr_q) + i;
      if (scan_idx >= NumPorts) begin
        scan_idx = scan_idx - NumPorts;
      end
      if (!any_req && req_ports_i[scan_idx[PtrW-1:0]].req) begin
        any_req = 1'b1;
        winner  = scan_idx[PtrW-1:0];
      end
    end
  end

  // A transaction ends on the response, which may coincide with the grant.
  assign complete = ((state_q == ST_REQ) && rsp_i.gnt && rsp_i.valid) ||
                    ((state_q == ST_WAIT) && rsp_i.valid);

  assign rr_next = (owner_q == PtrW'(NumPorts - 1)) ? '0 : owner_q + 1'b1;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Owner, captured payload and fairness pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q      <= '0;
      owner_q   <= '0;
      payload_q <= '0;
    end else begin
      if ((state_q == ST_IDLE) && any_req) begin
        owner_q   <= winner;
        payload_q <= req_ports_i[winner];
      end
      if (complete) begin
        rr_q <= rr_next;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_req) state_d = ST_REQ;
      ST_REQ: begin
        if (rsp_i.gnt) begin
          state_d = rsp_i.valid ? ST_IDLE : ST_WAIT;
        end
      end
      ST_WAIT: if (rsp_i.valid) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: grant and response are steered combinationally to the owner only.
  always_comb begin
    req_o       = '0;
    rsp_ports_o = '0;
    busy_o      = (state_q != ST_IDLE);
    case (state_q)
      ST_REQ: begin
        req_o     = payload_q;
        req_o.req = 1'b1;
        req_o.id  = 4'(owner_q);
        rsp_ports_o[owner_q].gnt = rsp_i.gnt;
        if (rsp_i.gnt && rsp_i.valid) begin
          rsp_ports_o[owner_q].valid = 1'b1;
          rsp_ports_o[owner_q].rdata = rsp_i.rdata;
        end
      end
      ST_WAIT: begin
        if (rsp_i.valid) begin
          rsp_ports_o[owner_q].valid = 1'b1;
          rsp_ports_o[owner_q].rdata = rsp_i.rdata;
        end
      end
      default: ;
    endcase
  end

  // A reset in the middle of a transaction leaves the adapter owing us a
  // response; remember that so its late arrival in IDLE is tolerated once.
  logic abandoned_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      abandoned_q <= abandoned_q | (state_q != ST_IDLE);
    end else if ((state_q == ST_IDLE) && (rsp_i.valid || any_req)) begin
      abandoned_q <= 1'b0;
    end
  end

  a_port_holds_req: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (state_q == ST_REQ) |-> req_ports_i[owner_q].req
  );

  a_no_rsp_in_idle: assert property (
    @(posedge clk_i) disable iff (rst_i)
    ((state_q == ST_IDLE) && !abandoned_q) |-> !(rsp_i.gnt || rsp_i.valid)
  );

endmodule

// File: tb/tb_std_cache_bypass_arbiter.sv
// tb/tb_std_cache_bypass_arbiter.sv - self-checking bench for std_cache_bypass_arbiter
module tb_std_cache_bypass_arbiter;
  import std_cache_bypass_pkg::*;

  localparam int NP = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  bypass_req_t [NP-1:0]  req_ports;
  bypass_rsp_t [NP-1:0]  rsp_ports;
  bypass_req_t           req_o;
  bypass_rsp_t           rsp;
  logic                  busy;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  std_cache_bypass_arbiter #(.NumPorts(NP)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_ports_i(req_ports),
    .rsp_ports_o(rsp_ports),
    .req_o      (req_o),
    .rsp_i      (rsp),
    .busy_o     (busy)
  );

  // Transaction-level reference: which port is being served, whether the
  // adapter has granted it yet, what was captured, and where the next search starts.
  int          m_cur;
  int          m_ptr;
  bit          m_granted;
  bypass_req_t m_payload;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_cycle();
    bypass_req_t          e_req;
    bypass_rsp_t [NP-1:0] e_rsp;
    #1;
    e_req = '0;
    e_rsp = '0;
    if (m_cur >= 0) begin
      if (!m_granted) begin
        e_req     = m_payload;
        e_req.req = 1'b1;
        e_req.id  = 4'(m_cur);
        e_rsp[m_cur].gnt = rsp.gnt;
        if (rsp.gnt && rsp.valid) begin
          e_rsp[m_cur].valid = 1'b1;
          e_rsp[m_cur].rdata = rsp.rdata;
        end
      end else if (rsp.valid) begin
        e_rsp[m_cur].valid = 1'b1;
        e_rsp[m_cur].rdata = rsp.rdata;
      end
    end
    chk("model_req_o", req_o, e_req);
    chk("model_rsp_ports", rsp_ports, e_rsp);
    chk("model_busy", busy, (m_cur >= 0));
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_cur = -1; m_ptr = 0; m_granted = 0; m_payload = '0;
    end else if (m_cur < 0) begin
      for (int d = 0; d < NP; d++) begin
        if (m_cur < 0 && req_ports[(m_ptr + d) % NP].req) begin
          m_cur     = (m_ptr + d) % NP;
          m_granted = 0;
          m_payload = req_ports[m_cur];
        end
      end
    end else if ((!m_granted && rsp.gnt && rsp.valid) || (m_granted && rsp.valid)) begin
      m_ptr = (m_cur + 1) % NP;
      m_cur = -1;
      m_granted = 0;
    end else if (!m_granted && rsp.gnt) begin
      m_granted = 1;
    end
    @(negedge clk);
  endtask

  function automatic bypass_req_t rand_req();
    bypass_req_t r;
    r.req   = 1'b1;
    r.we    = 1'($urandom);
    r.be    = 8'($urandom);
    r.id    = 4'($urandom);
    r.addr  = {$urandom, $urandom};
    r.wdata = {$urandom, $urandom};
    return r;
  endfunction

  function automatic bypass_req_t base_req(input int k);
    bypass_req_t r;
    r       = '0;
    r.be    = 8'hFF;
    r.id    = 4'hF;
    r.addr  = 64'h8000_0000 + 64'(k) * 64'h40;
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req_ports = '0; rsp = '0;
    advance();
    advance();
    rst = 1'b0;
  endtask

  // Wait for req_o.req, check the id, answer with gnt+valid together.
  task automatic serve_next(input int exp_id, output int gap);
    int n = 0;
    rsp = '0;
    check_cycle();
    while (!req_o.req && n < 20) begin
      advance(); n++; check_cycle();
    end
    gap = n;
    if (!req_o.req) begin
      n_checks++; n_err++;
      $display("FAIL serve_timeout: req_o.req stayed 0 waiting for port %0d", exp_id);
    end else begin
      chk("serve_id", req_o.id, exp_id);
      rsp.gnt = 1'b1; rsp.valid = 1'b1; rsp.rdata = 64'h1234 + 64'(exp_id);
      check_cycle();
      chk("serve_gnt", rsp_ports[exp_id].gnt, 1);
      chk("serve_valid", rsp_ports[exp_id].valid, 1);
      advance();
      req_ports[exp_id].req = 1'b0;
      rsp = '0;
    end
  endtask

  typedef struct {
    logic        rst;
    logic [2:0]  mask;
    logic        gnt;
    logic        valid;
    logic [63:0] rdata;
    logic        e_req;
    logic [3:0]  e_id;
    logic [2:0]  e_gnt;
    logic [2:0]  e_valid;
    logic        e_busy;
  } vec_t;

  function automatic vec_t mk(logic r, logic [2:0] m, logic g, logic v, logic [63:0] d,
                              logic er, logic [3:0] ei, logic [2:0] eg, logic [2:0] ev, logic eb);
    vec_t t;
    t.rst = r; t.mask = m; t.gnt = g; t.valid = v; t.rdata = d;
    t.e_req = er; t.e_id = ei; t.e_gnt = eg; t.e_valid = ev; t.e_busy = eb;
    return t;
  endfunction

  initial begin
    vec_t tbl[12];
    int   gap;
    int   gcnt[NP];
    int   vcnt[NP];
    int   exp_order;
    logic [2:0] g_obs, v_obs;
    bit   got_gnt[NP];

    // single read on port 1, then same-cycle gnt+valid on port 0
    tbl[0]  = mk(1, 3'b000, 0, 0, 64'h0,                  0, 0, 3'b000, 3'b000, 0);
    tbl[1]  = mk(0, 3'b010, 0, 0, 64'h0,                  0, 0, 3'b000, 3'b000, 0);
    tbl[2]  = mk(0, 3'b010, 0, 0, 64'h0,                  1, 1, 3'b000, 3'b000, 1);
    tbl[3]  = mk(0, 3'b010, 0, 0, 64'h0,                  1, 1, 3'b000, 3'b000, 1);
    tbl[4]  = mk(0, 3'b010, 1, 0, 64'h0,                  1, 1, 3'b010, 3'b000, 1);
    tbl[5]  = mk(0, 3'b000, 0, 0, 64'h0,                  0, 0, 3'b000, 3'b000, 1);
    tbl[6]  = mk(0, 3'b000, 0, 0, 64'h0,                  0, 0, 3'b000, 3'b000, 1);
    tbl[7]  = mk(0, 3'b000, 0, 1, 64'hDEAD_BEEF_0123_4567, 0, 0, 3'b000, 3'b010, 1);
    tbl[8]  = mk(0, 3'b000, 0, 0, 64'h0,                  0, 0, 3'b000, 3'b000, 0);
    tbl[9]  = mk(0, 3'b001, 0, 0, 64'h0,                  0, 0, 3'b000, 3'b000, 0);
    tbl[10] = mk(0, 3'b001, 1, 1, 64'h1,                  1, 0, 3'b001, 3'b001, 1);
    tbl[11] = mk(0, 3'b000, 0, 0, 64'h0,                  0, 0, 3'b000, 3'b000, 0);

    m_cur = -1; m_ptr = 0; m_granted = 0; m_payload = '0;
    rst = 1'b1; req_ports = '0; rsp = '0;
    @(negedge clk);
    do_reset();
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst;
      for (int k = 0; k < NP; k++) begin
        req_ports[k]     = base_req(k);
        req_ports[k].req = tbl[i].mask[k];
      end
      rsp.gnt = tbl[i].gnt; rsp.valid = tbl[i].valid; rsp.rdata = tbl[i].rdata;
      check_cycle();
      chk($sformatf("tbl%0d_req", i), req_o.req, tbl[i].e_req);
      if (tbl[i].e_req) begin
        chk($sformatf("tbl%0d_id", i), req_o.id, tbl[i].e_id);
        chk($sformatf("tbl%0d_addr", i), req_o.addr, 64'h8000_0000 + 64'(tbl[i].e_id) * 64'h40);
      end
      for (int k = 0; k < NP; k++) begin
        g_obs[k] = rsp_ports[k].gnt;
        v_obs[k] = rsp_ports[k].valid;
        chk($sformatf("tbl%0d_rdata%0d", i, k), rsp_ports[k].rdata,
            tbl[i].e_valid[k] ? tbl[i].rdata : 64'h0);
      end
      chk($sformatf("tbl%0d_gnt", i), g_obs, tbl[i].e_gnt);
      chk($sformatf("tbl%0d_valid", i), v_obs, tbl[i].e_valid);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      advance();
    end
    req_ports = '0; rsp = '0;

    // fairness: all ports request continuously, 4 writes each, immediate gnt+valid
    do_reset();
    exp_order = 0;
    for (int k = 0; k < NP; k++) begin gcnt[k] = 0; vcnt[k] = 0; end
    for (int c = 0; c < 100; c++) begin
      for (int k = 0; k < NP; k++) begin
        req_ports[k]     = base_req(k);
        req_ports[k].we  = 1'b1;
        req_ports[k].req = (gcnt[k] < 4);
      end
      rsp.gnt   = (m_cur >= 0) && !m_granted;
      rsp.valid = rsp.gnt;
      rsp.rdata = 64'(c);
      check_cycle();
      for (int k = 0; k < NP; k++) begin
        if (rsp_ports[k].gnt) begin
          chk("fair_order", k, exp_order);
          exp_order = (exp_order + 1) % NP;
          gcnt[k]++;
        end
        if (rsp_ports[k].valid) vcnt[k]++;
      end
      advance();
    end
    for (int k = 0; k < NP; k++) begin
      chk($sformatf("fair_gnt_cnt%0d", k), gcnt[k], 4);
      chk($sformatf("fair_valid_cnt%0d", k), vcnt[k], 4);
    end
    req_ports = '0; rsp = '0;

    // reset in WAIT for port 2, late valid afterwards is dropped
    do_reset();
    req_ports[2] = rand_req();
    check_cycle(); advance();
    check_cycle();
    chk("rst_seq_req", req_o.req, 1);
    rsp.gnt = 1'b1;
    check_cycle(); advance();
    req_ports[2].req = 1'b0; rsp = '0;
    check_cycle();
    chk("rst_seq_wait_busy", busy, 1);
    advance();
    rst = 1'b1;
    check_cycle(); advance();
    rst = 1'b0;
    check_cycle();
    chk("rst_req_o_zero", req_o, 0);
    chk("rst_rsp_zero", rsp_ports, 0);
    chk("rst_busy_zero", busy, 0);
    advance();
    check_cycle(); advance();
    rsp.valid = 1'b1; rsp.rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    check_cycle();
    chk("late_valid_dropped", rsp_ports, 0);
    chk("late_valid_busy", busy, 0);
    advance();
    rsp = '0;
    req_ports[0] = rand_req();
    serve_next(0, gap);

    // payload isolation: wdata change after capture is not seen
    req_ports[0] = base_req(0);
    req_ports[0].req = 1'b1; req_ports[0].we = 1'b1; req_ports[0].wdata = 64'hAA;
    check_cycle(); advance();
    req_ports[0].wdata = 64'hBB;
    check_cycle();
    chk("iso_wdata_a", req_o.wdata, 64'hAA);
    advance();
    check_cycle();
    chk("iso_wdata_b", req_o.wdata, 64'hAA);
    rsp.gnt = 1'b1; rsp.valid = 1'b1; rsp.rdata = 64'h0;
    check_cycle();
    chk("iso_wdata_gnt", req_o.wdata, 64'hAA);
    advance();
    req_ports[0].req = 1'b0; rsp = '0;

    // back-to-back with pointer wrap
    do_reset();
    req_ports[1] = rand_req();
    serve_next(1, gap);
    chk("b2b_first_latency", gap, 1);
    req_ports[0] = rand_req();
    req_ports[1] = rand_req();
    req_ports[2] = rand_req();
    serve_next(2, gap);
    chk("b2b_gap_p2", gap, 1);
    serve_next(0, gap);
    chk("b2b_gap_p0", gap, 1);
    serve_next(1, gap);
    chk("b2b_gap_p1", gap, 1);

    // randomized traffic against the reference
    for (int k = 0; k < NP; k++) got_gnt[k] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < NP; k++) begin
        if (req_ports[k].req) begin
          if (got_gnt[k]) begin
            if ($urandom_range(1, 0) == 0) req_ports[k].req = 1'b0;
            else req_ports[k] = rand_req();
          end
        end else if ($urandom_range(9, 0) < 3) begin
          req_ports[k] = rand_req();
        end
      end
      rsp = '0;
      rsp.rdata = {$urandom, $urandom};
      if (m_cur >= 0 && !m_granted) begin
        rsp.gnt   = 1'($urandom_range(1, 0));
        rsp.valid = rsp.gnt && ($urandom_range(1, 0) == 1);
      end else if (m_cur >= 0) begin
        rsp.valid = ($urandom_range(2, 0) == 0);
      end
      check_cycle();
      for (int k = 0; k < NP; k++) got_gnt[k] = rsp_ports[k].gnt;
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
